drop_policy_ctrl: RTL and testbench
===================================

DROP_POLICY_CTRL -- requirements
Module: drop_policy_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the pass/drop period counts.
REQ-002 Parameter STAT_W, default 16: width of the statistics counters.
REQ-003 Port clk_lookup  in  1  sole clock; all state is updated on its rising edge.
REQ-004 Port rst  in  1  reset; asynchronous, active-high.
REQ-005 Port cfg_enable  in  1  1 = apply the drop policy; 0 = pass every packet.
REQ-006 Port cfg_pass_cnt  in  CNT_W  P: number of packets passed per period.
REQ-007 Port cfg_drop_cnt  in  CNT_W  D: number of packets dropped per period.
REQ-008 Port cfg_load  in  1  single-cycle pulse; captures cfg_pass_cnt/cfg_drop_cnt into the shadow registers.
REQ-009 Port stat_clr  in  1  single-cycle pulse; zeroes both statistics counters.
REQ-010 Port pkt_valid  in  1  one cycle per packet needing a drop decision.
REQ-011 Port tuple_out_drop_or_not_input_VALID  out  1  decision valid; drives the drop_or_not tuple input.
REQ-012 Port tuple_out_drop_or_not_input_DATA  out  1  decision: 1 = drop, 0 = pass.
REQ-013 Port stat_dropped  out  STAT_W  saturating count of drop decisions.
REQ-014 Port stat_passed  out  STAT_W  saturating count of pass decisions.
REQ-015 Port state_o  out  2  current FSM state: 00 DISABLED, 01 PASS, 10 DROP.

Function
REQ-016 Active (P_a, D_a) and shadow (P_s, D_s) registers SHALL exist; cfg_load writes the shadow registers and sets a pending flag.
REQ-017 A pending shadow SHALL be copied to active only at a period boundary (DISABLED->PASS/DROP entry, or the last DROP of a period); the pending flag then clears.
REQ-018 If cfg_load coincides with a boundary, the newly loaded values SHALL take effect at that boundary.
REQ-019 Outputs SHALL be registered: for pkt_valid high in cycle n, VALID=1 in cycle n+1 carrying that packet's decision; VALID=0 otherwise.
REQ-020 Back-to-back pkt_valid (every cycle) SHALL be supported at full rate with no decision lost.
REQ-021 DISABLED: every packet gets DATA=0; when cfg_enable=1, the next cycle enters PASS if P_a>0, else DROP if D_a>0, else stays DISABLED.
REQ-022 PASS: each packet gets DATA=0 and increments the phase counter; on the P_a-th packet the phase counter clears and the FSM goes to DROP if D_a>0, else restarts PASS.
REQ-023 DROP: each packet gets DATA=1; on the D_a-th packet the phase counter clears (boundary) and the FSM goes to PASS if P_a>0, else restarts DROP.
REQ-024 P_a=0 and D_a=0 with cfg_enable=1 SHALL behave as DISABLED (all pass), with state_o=00.
REQ-025 cfg_enable falling in any state SHALL move the FSM to DISABLED next cycle and clear the phase counter; a packet in that same cycle is decided by the pre-transition state.
REQ-026 The phase counter SHALL be CNT_W bits and SHALL never wrap; it clears at the P_a/D_a terminal count.
REQ-027 stat_dropped/stat_passed SHALL increment on each emitted decision of that kind and saturate at all-ones.
REQ-028 stat_clr coincident with an increment SHALL yield 0 (clear wins).

Reset
REQ-029 rst=1 SHALL immediately force: state DISABLED, phase counter 0, P_a=P_s=D_a=D_s=0, pending 0, VALID=0, DATA=0, both stats 0.
REQ-030 rst asserted mid-period SHALL discard any in-flight decision; no VALID is emitted for a packet sampled in the reset cycle.

Verification
REQ-031 Reset, cfg_load P=3 D=1, enable, 8 consecutive pkt_valid -> DATA sequence 0,0,0,1,0,0,0,1 each one cycle later; stat_passed=6, stat_dropped=2.
REQ-032 P=2 D=2 active, after 1st packet cfg_load P=1 D=0 -> remaining old period 0,1,1, then all 0; state_o stays 01 after the boundary.
REQ-033 P=0 D=0 enabled, 5 packets -> all DATA=0, state_o=00, stat_passed=5.
REQ-034 STAT_W=4, P=1 D=0, 20 packets -> stat_passed holds 15; stat_clr with a packet in the same cycle -> 0 afterward.
REQ-035 P=4 D=2, rst pulse after 2 packets, reload P=4 D=2, re-enable -> decisions restart 0,0,0,0,1,1; no VALID during reset.
REQ-036 P=2 D=1, cfg_enable dropped after the 2nd packet -> 3rd packet DATA=1 if it coincides with the fall cycle, else DATA=0; state_o=00 next cycle.

Source files
------------

// File: rtl/drop_policy_ctrl.sv
// Periodic pass/drop decision generator with shadowed period config
// and saturating decision statistics.
module drop_policy_ctrl #(
   parameter int CNT_W  = 8,
   parameter int STAT_W = 16
) (
   input  logic              clk_lookup,
   input  logic              rst,
   input  logic              cfg_enable,
   input  logic [CNT_W-1:0]  cfg_pass_cnt,
   input  logic [CNT_W-1:0]  cfg_drop_cnt,
   input  logic              cfg_load,
   input  logic              stat_clr,
   input  logic              pkt_valid,
   output logic              tuple_out_drop_or_not_input_VALID,
   output logic              tuple_out_drop_or_not_input_DATA,
   output logic [STAT_W-1:0] stat_dropped,
   output logic [STAT_W-1:0] stat_passed,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_DIS  = 2'b00,
      ST_PASS = 2'b01,
      ST_DROP = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  pass_a_q, drop_a_q;
   logic [CNT_W-1:0]  pass_s_q, drop_s_q;
   logic              pend_q;

   logic [CNT_W-1:0]  pass_s_eff, drop_s_eff;
   logic [CNT_W-1:0]  pass_b, drop_b;
   logic              pend_eff;
   logic              bound;
   logic              pass_term, drop_term;
   logic              drop_dec;
   logic              valid_q, data_q;

   // A load in the boundary cycle itself must already be visible there.
   assign pass_s_eff = cfg_load ? cfg_pass_cnt : pass_s_q;
   assign drop_s_eff = cfg_load ? cfg_drop_cnt : drop_s_q;
   assign pend_eff   = cfg_load | pend_q;

   // Values in force after a boundary, whether or not one happens.
   assign pass_b = pend_eff ? pass_s_eff : pass_a_q;
   assign drop_b = pend_eff ? drop_s_eff : drop_a_q;

   assign pass_term = (cnt_q == pass_a_q - CNT_W'(1));
   assign drop_term = (cnt_q == drop_a_q - CNT_W'(1));

   function automatic state_t pick(input logic [CNT_W-1:0] p,
                                   input logic [CNT_W-1:0] d);
      if (p != '0)
         return ST_PASS;
      else if (d != '0)
         return ST_DROP;
      else
         return ST_DIS;
   endfunction

   always_ff @(posedge clk_lookup or posedge rst) begin
      if (rst) begin
         state_q <= ST_DIS;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bound   = 1'b0;
      if (!cfg_enable) begin
         state_d = ST_DIS;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_DIS: begin
               bound   = 1'b1;
               cnt_d   = '0;
               state_d = pick(pass_b, drop_b);
            end
            ST_PASS: begin
               if (pkt_valid) begin
                  if (pass_term) begin
                     cnt_d = '0;
                     if (drop_a_q != '0) begin
                        state_d = ST_DROP;
                     end else begin
                        // No drop phase: this pass ends the period.
                        bound   = 1'b1;
                        state_d = pick(pass_b, drop_b);
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_DROP: begin
               if (pkt_valid) begin
                  if (drop_term) begin
                     cnt_d   = '0;
                     bound   = 1'b1;
                     state_d = pick(pass_b, drop_b);
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_DIS;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      drop_dec = (state_q == ST_DROP);
      state_o  = state_q;
   end

   always_ff @(posedge clk_lookup or posedge rst) begin
      if (rst) begin
         pass_s_q <= '0;
         drop_s_q <= '0;
         pass_a_q <= '0;
         drop_a_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         if (cfg_load) begin
            pass_s_q <= cfg_pass_cnt;
            drop_s_q <= cfg_drop_cnt;
         end
         if (bound && pend_eff) begin
            pass_a_q <= pass_s_eff;
            drop_a_q <= drop_s_eff;
            pend_q   <= 1'b0;
         end else if (cfg_load) begin
            pend_q   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_lookup or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= 1'b0;
      end else begin
         valid_q <= pkt_valid;
         data_q  <= pkt_valid & drop_dec;
      end
   end

   always_ff @(posedge clk_lookup or posedge rst) begin
      if (rst) begin
         stat_dropped <= '0;
         stat_passed  <= '0;
      end else if (stat_clr) begin
         stat_dropped <= '0;
         stat_passed  <= '0;
      end else if (pkt_valid) begin
         if (drop_dec && stat_dropped != '1)
            stat_dropped <= stat_dropped + STAT_W'(1);
         if (!drop_dec && stat_passed != '1)
            stat_passed <= stat_passed + STAT_W'(1);
      end
   end

   assign tuple_out_drop_or_not_input_VALID = valid_q;
   assign tuple_out_drop_or_not_input_DATA  = data_q;

endmodule

// File: tb/tb_drop_policy_ctrl.sv
// Directed bench for drop_policy_ctrl: period sequencing, config
// shadowing, enable/reset interaction and statistics saturation.
module tb_drop_policy_ctrl;

   localparam int CNT_W  = 8;
   localparam int STAT_W = 4;

   logic              clk_lookup = 1'b0;
   logic              rst;
   logic              cfg_enable;
   logic [CNT_W-1:0]  cfg_pass_cnt;
   logic [CNT_W-1:0]  cfg_drop_cnt;
   logic              cfg_load;
   logic              stat_clr;
   logic              pkt_valid;
   logic              vld;
   logic              dat;
   logic [STAT_W-1:0] stat_dropped;
   logic [STAT_W-1:0] stat_passed;
   logic [1:0]        state_o;

   int n_chk = 0;
   int n_err = 0;

   drop_policy_ctrl #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
      .clk_lookup                        (clk_lookup),
      .rst                               (rst),
      .cfg_enable                        (cfg_enable),
      .cfg_pass_cnt                      (cfg_pass_cnt),
      .cfg_drop_cnt                      (cfg_drop_cnt),
      .cfg_load                          (cfg_load),
      .stat_clr                          (stat_clr),
      .pkt_valid                         (pkt_valid),
      .tuple_out_drop_or_not_input_VALID (vld),
      .tuple_out_drop_or_not_input_DATA  (dat),
      .stat_dropped                      (stat_dropped),
      .stat_passed                       (stat_passed),
      .state_o                           (state_o)
   );

   always #5 clk_lookup = ~clk_lookup;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_lookup);
      #1;
   endtask

   task automatic load(input int p, input int d);
      cfg_pass_cnt = CNT_W'(p);
      cfg_drop_cnt = CNT_W'(d);
      cfg_load     = 1'b1;
      tick();
      cfg_load     = 1'b0;
   endtask

   task automatic clr_stats();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
   endtask

   // Back-to-back packets; each decision is checked one cycle later.
   task automatic burst(input string tag, input int n, input logic [31:0] exp);
      for (int i = 0; i < n; i++) begin
         pkt_valid = 1'b1;
         tick();
         chk({tag, "_vld"}, int'(vld), 1);
         chk({tag, "_dat"}, int'(dat), int'(exp[i]));
      end
      pkt_valid = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      cfg_enable   = 1'b0;
      cfg_pass_cnt = '0;
      cfg_drop_cnt = '0;
      cfg_load     = 1'b0;
      stat_clr     = 1'b0;
      pkt_valid    = 1'b0;
      tick();
      tick();
      chk("rst_vld",   int'(vld), 0);
      chk("rst_dat",   int'(dat), 0);
      chk("rst_state", int'(state_o), 0);
      chk("rst_sdrop", int'(stat_dropped), 0);
      chk("rst_spass", int'(stat_passed), 0);
      rst = 1'b0;
      tick();

      // P=3 D=1: 0,0,0,1,0,0,0,1 (bit i = packet i)
      load(3, 1);
      cfg_enable = 1'b1;
      tick();
      chk("t1_state", int'(state_o), 1);
      burst("t1", 8, 32'b1000_1000);
      tick();
      chk("t1_idle", int'(vld), 0);
      chk("t1_spass", int'(stat_passed), 6);
      chk("t1_sdrop", int'(stat_dropped), 2);

      // P=2 D=2, reload P=1 D=0 mid-period: 0,0,1,1,0,0
      cfg_enable = 1'b0;
      tick();
      clr_stats();
      load(2, 2);
      cfg_enable = 1'b1;
      tick();
      pkt_valid = 1'b1;
      tick();
      chk("t2_p1", int'(dat), 0);
      cfg_pass_cnt = 8'd1;
      cfg_drop_cnt = 8'd0;
      cfg_load     = 1'b1;
      tick();
      cfg_load     = 1'b0;
      chk("t2_p2", int'(dat), 0);
      burst("t2", 4, 32'b0011);
      chk("t2_state", int'(state_o), 1);
      chk("t2_sdrop", int'(stat_dropped), 2);

      // P=0 D=0 while enabled behaves as disabled
      cfg_enable = 1'b0;
      tick();
      clr_stats();
      load(0, 0);
      cfg_enable = 1'b1;
      tick();
      chk("t3_state0", int'(state_o), 0);
      burst("t3", 5, 32'b0);
      chk("t3_state", int'(state_o), 0);
      chk("t3_spass", int'(stat_passed), 5);

      // Saturation of the 4-bit counter, then clear beats increment
      cfg_enable = 1'b0;
      tick();
      clr_stats();
      load(1, 0);
      cfg_enable = 1'b1;
      tick();
      burst("t4", 20, 32'b0);
      chk("t4_sat", int'(stat_passed), 15);
      pkt_valid = 1'b1;
      stat_clr  = 1'b1;
      tick();
      pkt_valid = 1'b0;
      stat_clr  = 1'b0;
      chk("t4_clr_vld", int'(vld), 1);
      chk("t4_clr", int'(stat_passed), 0);

      // Reset mid-period discards the in-flight packet
      cfg_enable = 1'b0;
      tick();
      load(4, 2);
      cfg_enable = 1'b1;
      tick();
      burst("t5a", 2, 32'b00);
      pkt_valid = 1'b1;
      rst       = 1'b1;
      #1;
      chk("t5_rst_now", int'(state_o), 0);
      tick();
      chk("t5_rst_vld", int'(vld), 0);
      chk("t5_rst_sp", int'(stat_passed), 0);
      pkt_valid  = 1'b0;
      cfg_enable = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      load(4, 2);
      cfg_enable = 1'b1;
      tick();
      burst("t5b", 6, 32'b110000);
      chk("t5_spass", int'(stat_passed), 4);
      chk("t5_sdrop", int'(stat_dropped), 2);

      // Enable falls coincident with the 3rd packet (in DROP)
      cfg_enable = 1'b0;
      tick();
      load(2, 1);
      cfg_enable = 1'b1;
      tick();
      burst("t6a", 2, 32'b00);
      chk("t6_drop", int'(state_o), 2);
      pkt_valid  = 1'b1;
      cfg_enable = 1'b0;
      tick();
      chk("t6_p3", int'(dat), 1);
      chk("t6_state", int'(state_o), 0);
      burst("t6b", 1, 32'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
